ir_transmitter: RTL and testbench

IR_TRANSMITTER -- requirements
Module: ir_transmitter

---
 rtl/ir_pkg.sv | 29 ++
 rtl/ir_carrier_gen.sv | 30 +++
 rtl/ir_transmitter.sv | 148 ++++++++++++++
 tb/tb_ir_transmitter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared state encoding and protocol timing constants for the IR transmitter.
// FRAME_WAIT only exists when IR_REPEAT_EN is defined.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    BIT,
    DONE
`ifdef IR_REPEAT_EN
    , FRAME_WAIT
`endif
  } ir_state_e;

  localparam int START_UNITS = 4;
  localparam int GAP_UNITS   = 1;
  localparam int ONE_UNITS   = 2;
  localparam int ZERO_UNITS  = 1;
  localparam int CMD_BITS    = 12;
  localparam int FRAME_UNITS = 75;
  localparam int REPEATS     = 3;

  // States during which the LED is driven with carrier.
  function automatic logic is_mark(input ir_state_e s);
    return (s == START) || (s == BIT);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier with CARRIER_HALF clocks per half period; a synchronous
// restart forces the carrier high with a fresh half period on the next cycle.
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 337
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic carrier
);
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  logic [CW-1:0] half_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      half_cnt <= '0;
      carrier  <= 1'b0;
    end else if (restart) begin
      half_cnt <= '0;
      carrier  <= 1'b1;
    end else if (half_cnt == CW'(CARRIER_HALF - 1)) begin
      half_cnt <= '0;
      carrier  <= ~carrier;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ir_transmitter.sv
// Pulse-distance IR transmitter: 4-unit start mark, then 12 bits LSB first,
// each a 1-unit space plus a 1- or 2-unit mark. IR_REPEAT_EN sends the frame 3 times.
module ir_transmitter
  import ir_pkg::*;
#(
  parameter int UNIT_CYCLES  = 16200,
  parameter int CARRIER_HALF = 337
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        transmit,
  input  logic [11:0] move_command,
  output logic        ir_out,
  output logic        busy,
  output logic        done,
  output ir_state_e   state_dbg
);
  localparam int PW = $clog2(START_UNITS * UNIT_CYCLES);
  localparam int BW = $clog2(CMD_BITS + 1);

  ir_state_e           state, state_next;
  logic [PW-1:0]       phase_cnt, phase_last;
  logic [CMD_BITS-1:0] shift_q;
  logic [BW-1:0]       bit_cnt;
  logic                phase_end, last_bit, accept, restart, carrier;

  assign accept    = (state == IDLE) && transmit;
  assign phase_end = (phase_cnt == phase_last);
  assign last_bit  = (bit_cnt == BW'(CMD_BITS - 1));

`ifdef IR_REPEAT_EN
  localparam int FW = $clog2(FRAME_UNITS * UNIT_CYCLES);

  logic [FW-1:0]       frame_cnt;
  logic [1:0]          rep_cnt;
  logic [CMD_BITS-1:0] cmd_q;
  logic                frame_end, last_frame, next_frame;

  assign frame_end  = (frame_cnt == FW'(FRAME_UNITS * UNIT_CYCLES - 1));
  assign last_frame = (rep_cnt == 2'(REPEATS - 1));
  assign next_frame = (state == FRAME_WAIT) && frame_end;

  // Frame-start timer; cmd_q restores the word for each repeat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      rep_cnt   <= '0;
      cmd_q     <= '0;
    end else if (accept) begin
      frame_cnt <= '0;
      rep_cnt   <= '0;
      cmd_q     <= move_command;
    end else if (next_frame) begin
      frame_cnt <= '0;
      rep_cnt   <= rep_cnt + 1'b1;
    end else if (state != IDLE) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    phase_last = '0;
    case (state)
      START:   phase_last = PW'(START_UNITS * UNIT_CYCLES - 1);
      GAP:     phase_last = PW'(GAP_UNITS * UNIT_CYCLES - 1);
      BIT:     phase_last = shift_q[0] ? PW'(ONE_UNITS * UNIT_CYCLES - 1)
                                       : PW'(ZERO_UNITS * UNIT_CYCLES - 1);
      default: phase_last = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // The space precedes each bit mark, so the frame ends on the last bit's mark.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (transmit) state_next = START;
      START: if (phase_end) state_next = GAP;
      GAP:   if (phase_end) state_next = BIT;
      BIT: begin
        if (phase_end) begin
          if (!last_bit) state_next = GAP;
`ifdef IR_REPEAT_EN
          else if (!last_frame) state_next = FRAME_WAIT;
`endif
          else state_next = DONE;
        end
      end
`ifdef IR_REPEAT_EN
      FRAME_WAIT: if (frame_end) state_next = START;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    ir_out    = is_mark(state) && carrier;
    restart   = is_mark(state_next) && (state_next != state);
    state_dbg = state;
  end

  // Phase timer reloads on every state change, so it never exceeds the start mark.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_cnt <= '0;
    end else if (state != state_next) begin
      phase_cnt <= '0;
    end else if ((state == START) || (state == GAP) || (state == BIT)) begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shift_q <= move_command;
      bit_cnt <= '0;
`ifdef IR_REPEAT_EN
    end else if (next_frame) begin
      shift_q <= cmd_q;
      bit_cnt <= '0;
`endif
    end else if ((state == BIT) && phase_end) begin
      shift_q <= shift_q >> 1;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  ir_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .clock  (clock),
    .reset  (reset),
    .restart(restart),
    .carrier(carrier)
  );

endmodule

// File: tb/tb_ir_transmitter.sv
// Bench for ir_transmitter: a waveform queue built from the protocol rules
// predicts {ir_out, busy, done} for every cycle; directed cases pin latencies.
module tb_ir_transmitter;
  import ir_pkg::*;

  localparam int U  = 8;
  localparam int CH = 2;
`ifdef IR_REPEAT_EN
  localparam int REPS    = 3;
  localparam int REP_OFF = 1200;
`else
  localparam int REPS    = 1;
  localparam int REP_OFF = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        transmit = 1'b0;
  logic [11:0] move_command = '0;
  logic        ir_out, busy, done;
  ir_state_e   state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;
  logic [2:0] exp_q[$];

  ir_transmitter #(
    .UNIT_CYCLES (U),
    .CARRIER_HALF(CH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .transmit    (transmit),
    .move_command(move_command),
    .ir_out      (ir_out),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One entry per cycle: {ir_out, busy, done}. Marks start their carrier high.
  task automatic push_run(input int ncyc, input bit mark);
    for (int c = 0; c < ncyc; c++)
      exp_q.push_back({mark && (((c / CH) % 2) == 0), 1'b1, 1'b0});
  endtask

  task automatic push_frame(input logic [11:0] cmd);
    for (int r = 0; r < REPS; r++) begin
      int start_sz;
      start_sz = exp_q.size();
      push_run(START_UNITS * U, 1'b1);
      for (int i = 0; i < 12; i++) begin
        push_run(U, 1'b0);
        push_run((cmd[i] ? 2 : 1) * U, 1'b1);
      end
      if (r < REPS - 1) push_run(FRAME_UNITS * U - (exp_q.size() - start_sz), 1'b0);
    end
    exp_q.push_back(3'b011);
  endtask

  // A request is taken only on an edge that ends an idle cycle.
  always @(posedge clock or negedge reset) begin
    if (!reset) exp_q.delete();
    else if (exp_q.size() == 0) begin
      if (transmit) push_frame(move_command);
    end else void'(exp_q.pop_front());
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin
    if (reset && cmp_en)
      check("cycle_outputs", {ir_out, busy, done}, (exp_q.size() != 0) ? exp_q[0] : 3'b000);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [11:0] cmd, output int acc);
    @(negedge clock);
    move_command = cmd;
    transmit = 1'b1;
    @(posedge clock);
    #1 acc = cyc;
    @(negedge clock);
    transmit = 1'b0;
  endtask

  task automatic wait_done(input int acc, input int exp_lat, input string name);
    int n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clock);
      n++;
    end
    check(name, cyc - acc, exp_lat);
  endtask

  task automatic finish_frame(input string name);
    @(negedge clock);
    check(name, busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int ones;
    int n;

    // Pin the model against hand-computed frame sizes.
    push_frame(12'h730);
    check("model_len_730", exp_q.size(), 265 + REP_OFF);
    ones = 0;
    for (int i = 0; i < 40; i++) ones += exp_q[i][2];
    check("model_first_mark_ones", ones, 16);
    exp_q.delete();
    push_frame(12'hFFF);
    check("model_len_fff", exp_q.size(), 321 + REP_OFF);
    exp_q.delete();

    repeat (3) @(negedge clock);
    check("reset_ir_out", ir_out, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_state", state_dbg, IDLE);
    reset = 1'b1;
    cmp_en = 1'b1;

    // 0x730: first mark 32 cycles of 2-high/2-low carrier, then a space.
    send(12'h730, acc);
    check("busy_after_accept", busy, 1'b1);
    ones = 0;
    for (int i = 0; i < 40; i++) begin
      ones += ir_out;
      @(negedge clock);
    end
    check("first_mark_ones", ones, 16);
    wait_done(acc, 264 + REP_OFF, "done_lat_730");
    finish_frame("idle_after_730");

    send(12'h000, acc);
    wait_done(acc, 224 + REP_OFF, "done_lat_000");
    finish_frame("idle_after_000");

    send(12'hFFF, acc);
    wait_done(acc, 320 + REP_OFF, "done_lat_fff");
    finish_frame("idle_after_fff");

    // Reset in the middle of the start mark clears outputs at once.
    send(12'h730, acc);
    repeat (5) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("midreset_ir_out", ir_out, 1'b0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_done", done, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    send(12'h730, acc);
    wait_done(acc, 264 + REP_OFF, "done_lat_after_reset");
    finish_frame("idle_after_reset_frame");

    // Held request with a changing command word during the frame.
    @(negedge clock);
    move_command = 12'h730;
    transmit = 1'b1;
    @(posedge clock);
    #1 acc = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      move_command = 12'h0FF;
    end
    transmit = 1'b0;
    wait_done(acc, 264 + REP_OFF, "done_lat_held_cmd");
    finish_frame("idle_after_held");

    // Request during the DONE cycle is dropped.
    send(12'h0A5, acc);
    wait_done(acc, 28 * U + 4 * U + REP_OFF, "done_lat_0a5");
    transmit = 1'b1;
    @(negedge clock);
    transmit = 1'b0;
    check("busy_falls_after_done", busy, 1'b0);
    @(negedge clock);
    check("done_cycle_request_ignored", busy, 1'b0);

    // Random requests and command churn; the scoreboard checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      transmit = ($urandom_range(0, 15) == 0);
      move_command = 12'($urandom);
    end
    transmit = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 4000) begin
      @(negedge clock);
      n++;
    end
    check("drain_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
